// File: rtl/lfsr_rng.sv
// Configurable Fibonacci/Galois LFSR random source with runtime seed load
// and a req/valid handshake that returns OUT_BITS freshly shifted-out bits.
module lfsr_rng #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] SEED     = 8'h6A,
    parameter bit               GALOIS   = 1'b0,
    parameter logic [WIDTH-1:0] FTAPS    = 8'h1D,
    parameter logic [WIDTH-1:0] GTAPS    = 8'hB8,
    parameter int unsigned      OUT_BITS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                req,
    output logic                busy,
    output logic                valid,
    output logic [OUT_BITS-1:0] rnd,
    output logic [WIDTH-1:0]    state
);

    localparam int unsigned     CW   = $clog2(OUT_BITS + 1);
    localparam logic [CW-1:0]   LAST = CW'(OUT_BITS - 1);

    typedef enum logic {IDLE, DRAW} fsm_t;

    fsm_t                st, st_nxt;
    logic [WIDTH-1:0]    lfsr, lfsr_nxt, stepped, advanced, held;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [OUT_BITS-1:0] acc, acc_nxt, shifted, rnd_q, rnd_nxt;
    logic                valid_q, valid_nxt;

    always_comb begin
        if (GALOIS)
            stepped = (lfsr >> 1) ^ ({WIDTH{lfsr[0]}} & GTAPS);
        else
            stepped = {^(lfsr & FTAPS), lfsr[WIDTH-1:1]};
    end

    // A zero state is a lock-up point; recover to SEED whether stepping or holding.
    assign advanced = (lfsr == '0) ? SEED : stepped;
    assign held     = (lfsr == '0) ? SEED : lfsr;

    // Bits enter at the MSB so the first collected bit lands in bit 0 after OUT_BITS shifts.
    always_comb begin
        shifted               = acc >> 1;
        shifted[OUT_BITS-1]   = lfsr[0];
    end

    always_comb begin
        st_nxt    = st;
        lfsr_nxt  = held;
        cnt_nxt   = cnt;
        acc_nxt   = acc;
        rnd_nxt   = rnd_q;
        valid_nxt = 1'b0;
        if (load) begin
            lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
            st_nxt   = IDLE;
            cnt_nxt  = '0;
        end else begin
            case (st)
                IDLE: begin
                    if (en)
                        lfsr_nxt = advanced;
                    if (req) begin
                        st_nxt  = DRAW;
                        cnt_nxt = '0;
                    end
                end
                DRAW: begin
                    lfsr_nxt = advanced;
                    acc_nxt  = shifted;
                    if (cnt == LAST) begin
                        rnd_nxt   = shifted;
                        valid_nxt = 1'b1;
                        st_nxt    = IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st      <= IDLE;
            lfsr    <= SEED;
            cnt     <= '0;
            acc     <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            st      <= st_nxt;
            lfsr    <= lfsr_nxt;
            cnt     <= cnt_nxt;
            acc     <= acc_nxt;
            rnd_q   <= rnd_nxt;
            valid_q <= valid_nxt;
        end
    end

    assign busy  = (st == DRAW);
    assign valid = valid_q;
    assign rnd   = rnd_q;
    assign state = lfsr;

endmodule

// File: tb/tb_lfsr_rng.sv
// Directed bench for lfsr_rng: per-cycle vector table on the default Fibonacci
// configuration plus hand-written async-reset, period and Galois draw sequences.
module tb_lfsr_rng;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, load, req;
    logic [7:0] seed_in;
    logic       busy, valid;
    logic [3:0] rnd;
    logic [7:0] state;

    logic       g_en, g_load, g_req;
    logic [7:0] g_seed;
    logic       g_busy, g_valid;
    logic [3:0] g_rnd;
    logic [7:0] g_state;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    lfsr_rng dut (
        .CLK(clk), .RST(rst), .en(en), .load(load), .seed_in(seed_in), .req(req),
        .busy(busy), .valid(valid), .rnd(rnd), .state(state)
    );

    lfsr_rng #(.WIDTH(8), .SEED(8'h01), .GALOIS(1'b1), .GTAPS(8'hB8), .OUT_BITS(4)) gdut (
        .CLK(clk), .RST(rst), .en(g_en), .load(g_load), .seed_in(g_seed), .req(g_req),
        .busy(g_busy), .valid(g_valid), .rnd(g_rnd), .state(g_state)
    );

    typedef struct {
        logic       load;
        logic [7:0] seed;
        logic       en;
        logic       req;
        logic [7:0] e_state;
        logic       e_busy;
        logic       e_valid;
        logic [3:0] e_rnd;
    } vec_t;

    vec_t vecs[29];

    function automatic vec_t mk(logic l, logic [7:0] s, logic e, logic r,
                                logic [7:0] es, logic eb, logic ev, logic [3:0] er);
        vec_t v;
        v.load = l; v.seed = s; v.en = e; v.req = r;
        v.e_state = es; v.e_busy = eb; v.e_valid = ev; v.e_rnd = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned edges;
        int unsigned zeros;
        int unsigned vcount;
        int unsigned last_v;
        int unsigned cyc;

        // load / draw / abort / back-to-back sequences, Fibonacci defaults
        vecs[0]  = mk(0, 8'h00, 1, 0, 8'hB5, 0, 0, 4'h0);
        vecs[1]  = mk(0, 8'h00, 0, 0, 8'hB5, 0, 0, 4'h0);
        vecs[2]  = mk(1, 8'h00, 0, 0, 8'h6A, 0, 0, 4'h0);
        vecs[3]  = mk(1, 8'h81, 1, 0, 8'h81, 0, 0, 4'h0);
        vecs[4]  = mk(1, 8'h6A, 0, 0, 8'h6A, 0, 0, 4'h0);
        vecs[5]  = mk(0, 8'h00, 0, 1, 8'h6A, 1, 0, 4'h0);
        vecs[6]  = mk(0, 8'h00, 0, 0, 8'hB5, 1, 0, 4'h0);
        vecs[7]  = mk(0, 8'h00, 1, 0, 8'hDA, 1, 0, 4'h0);
        vecs[8]  = mk(0, 8'h00, 0, 0, 8'h6D, 1, 0, 4'h0);
        vecs[9]  = mk(0, 8'h00, 0, 0, 8'hB6, 0, 1, 4'hA);
        vecs[10] = mk(0, 8'h00, 0, 0, 8'hB6, 0, 0, 4'hA);
        vecs[11] = mk(0, 8'h00, 0, 1, 8'hB6, 1, 0, 4'hA);
        vecs[12] = mk(0, 8'h00, 0, 0, 8'h5B, 1, 0, 4'hA);
        vecs[13] = mk(0, 8'h00, 0, 0, 8'hAD, 1, 0, 4'hA);
        vecs[14] = mk(1, 8'h55, 0, 0, 8'h55, 0, 0, 4'hA);
        vecs[15] = mk(0, 8'h00, 0, 0, 8'h55, 0, 0, 4'hA);
        vecs[16] = mk(1, 8'h81, 0, 1, 8'h81, 0, 0, 4'hA);
        vecs[17] = mk(0, 8'h00, 0, 0, 8'h81, 0, 0, 4'hA);
        vecs[18] = mk(0, 8'h00, 1, 1, 8'hC0, 1, 0, 4'hA);
        vecs[19] = mk(0, 8'h00, 0, 0, 8'h60, 1, 0, 4'hA);
        vecs[20] = mk(0, 8'h00, 0, 0, 8'h30, 1, 0, 4'hA);
        vecs[21] = mk(0, 8'h00, 0, 0, 8'h98, 1, 0, 4'hA);
        vecs[22] = mk(0, 8'h00, 0, 0, 8'h4C, 0, 1, 4'h0);
        vecs[23] = mk(0, 8'h00, 0, 1, 8'h4C, 1, 0, 4'h0);
        vecs[24] = mk(0, 8'h00, 0, 1, 8'h26, 1, 0, 4'h0);
        vecs[25] = mk(0, 8'h00, 1, 1, 8'h93, 1, 0, 4'h0);
        vecs[26] = mk(0, 8'h00, 0, 1, 8'h49, 1, 0, 4'h0);
        vecs[27] = mk(0, 8'h00, 0, 1, 8'h24, 0, 1, 4'hC);
        vecs[28] = mk(0, 8'h00, 0, 0, 8'h24, 0, 0, 4'hC);

        rst = 1'b1; en = 1'b0; load = 1'b0; req = 1'b0; seed_in = 8'h00;
        g_en = 1'b0; g_load = 1'b0; g_req = 1'b0; g_seed = 8'h00;
        #1;
        check("reset_state", 32'(state), 32'h6A);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_rnd", 32'(rnd), 32'h0);
        check("g_reset_state", 32'(g_state), 32'h01);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 29; i++) begin
            load = vecs[i].load; seed_in = vecs[i].seed; en = vecs[i].en; req = vecs[i].req;
            @(posedge clk); #1;
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            check($sformatf("vec%0d_valid", i), 32'(valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d_rnd", i), 32'(rnd), 32'(vecs[i].e_rnd));
        end
        load = 1'b0; en = 1'b0; req = 1'b0;

        // asynchronous reset between edges, two bits into a draw
        req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 32'h6A);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_valid", 32'(valid), 32'h0);
        check("async_rst_rnd", 32'(rnd), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // full period of the default Fibonacci configuration
        en = 1'b1; g_en = 1'b1;
        edges = 0; zeros = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (state == 8'h00) zeros++;
            if (edges == 1) check("fib_first_step", 32'(state), 32'hB5);
        end while (state != 8'h6A && edges < 300);
        check("fib_period", edges, 255);
        check("fib_no_zero", zeros, 0);
        en = 1'b0;

        // Galois period from 0x01; gdut has been stepping in lockstep
        edges = 0; zeros = 0;
        g_en = 1'b0;
        check("g_start", 32'(g_state), 32'h01);
        g_en = 1'b1;
        do begin
            @(posedge clk); #1;
            edges++;
            if (g_state == 8'h00) zeros++;
            if (edges == 1) check("g_step1", 32'(g_state), 32'hB8);
            if (edges == 2) check("g_step2", 32'(g_state), 32'h5C);
        end while (g_state != 8'h01 && edges < 300);
        check("g_period", edges, 255);
        check("g_no_zero", zeros, 0);
        g_en = 1'b0;

        // req held high: one pulse every OUT_BITS+1 cycles
        g_req = 1'b1;
        vcount = 0; last_v = 0; cyc = 0;
        while (vcount < 4 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (g_valid) begin
                vcount++;
                if (vcount == 1) begin
                    check("g_first_rnd", 32'(g_rnd), 32'h1);
                    check("g_first_state", 32'(g_state), 32'h17);
                    check("g_first_latency", cyc, 5);
                end else begin
                    check($sformatf("g_interval%0d", vcount - 1), cyc - last_v, 5);
                end
                last_v = cyc;
            end
        end
        check("g_valid_count", vcount, 4);
        g_req = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
